id_stage_hazard: RTL and testbench
==================================

# id_stage_hazard

Pipelined instruction-decode stage for the 5-stage MIPS core: parametrised register file, in-stage branch/jump resolution, load-use and branch-operand hazard detection, and its own registered ID/EX pipeline register with a valid bit. It sits between the IF/ID register and the execute stage. It also adds a saturating stall-cycle counter for performance measurement.

## Interface
- Parameters:
- NREG_LOG2, 5, register-address width; valid 3..5; register file holds 2**NREG_LOG2 words.
- CTRL_W, 16, width of the external controller's control word, carried unmodified to EX.
- STALL_CTR_W, 16, width of the stall-cycle counter.
- Ports:
- Clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-high.
- if_valid  in  1  IF/ID holds a real instruction.
- if_instr  in  32  instruction from IF/ID.
- if_pc4  in  32  PC+4 of that instruction.
- ctrl_in  in  CTRL_W  control word for if_instr from the controller (combinational).
- exmem_regdst  in  NREG_LOG2  EX/MEM destination register.
- exmem_regwrite  in  1  EX/MEM writes a register.
- exmem_memread  in  1  EX/MEM is a load.
- exmem_fwd_data  in  32  EX/MEM ALU result, used for branch-operand forwarding.
- wb_we, wb_addr[NREG_LOG2], wb_data[32]  in  write-back port.
- flush  in  1  squash the instruction in decode.
- id_ready  out  1  PC and IF/ID may advance (PCWrite = IF_IDWrite).
- redirect_valid  out  1  taken branch/jump resolved this cycle.
- redirect_pc  out  32  target PC.
- ex_valid  out  1  ID/EX register holds a real instruction.
- ex_ctrl[CTRL_W], ex_pc4[32], ex_rs_data[32], ex_rt_data[32], ex_imm[32], ex_rs/ex_rt/ex_rd/ex_dest[NREG_LOG2], ex_shamt[5], ex_funct[6], ex_opcode[6], ex_regwrite, ex_memread  out  registered ID/EX fields.
- stall_cycles  out  STALL_CTR_W  saturating count of stall cycles.

## Operation
- Register fields: rs=instr[21+:NREG_LOG2], rt=instr[16+:NREG_LOG2], rd=instr[11+:NREG_LOG2]. Upper field bits are ignored when NREG_LOG2<5.
- Register file: register 0 reads 0 and ignores writes. Write on Clk when wb_we. A same-cycle read of wb_addr (nonzero) returns wb_data (bypass).
- Internal decode: regwrite=1 for R-type except jr (op 0, funct 08), and for op 23 (lw), 08, 09, 0A, 0C, 0D, 0E, 0F, 03 (jal). memread=1 for op 23 only.
- Destination: rd for R-type, 31 for jal, rt otherwise.
- Immediate: sign-extended instr[15:0].
- Branch/jump: beq op 04, bne op 05, j op 02, jal op 03, jr.
  - Branch target = pc4 + (imm<<2).
  - Jump target = {pc4[31:28], instr[25:0], 2'b00}.
  - jr target = rs operand.
- Branch-operand source: EX/MEM forward (exmem_regwrite & !exmem_memread & exmem_regdst==reg & reg!=0) > register file.
- Stall conditions; each applies only when if_valid and the decoded instruction is not j.
  - Load-use: ex_valid & ex_memread & ex_dest!=0 & ex_dest∈{rs,rt}.
  - Branch/jr operand hazard: ex_valid & ex_regwrite & ex_dest!=0 & ex_dest matches an operand the instruction uses (beq/bne: rs, rt; jr: rs).
  - Branch/jr load hazard: exmem_memread & exmem_regdst!=0 & exmem_regdst matches a used operand.
- Stall: id_ready=0, redirect_valid=0, and a bubble (ex_valid=0) enters ID/EX. Stalls are held until the hazard clears. A branch on a just-issued load therefore stalls 2 cycles; a branch on an ALU result stalls 1.
- redirect_valid = if_valid & !stall & !flush & (j | jal | jr | beq-equal | bne-not-equal).
- Priority: Reset > flush > stall > normal.
- flush: ID/EX receives a bubble, redirect_valid=0, id_ready=1.
- Normal: ID/EX loads all fields and ex_valid<=if_valid.
- stall_cycles increments on every cycle where the stall condition holds and flush=0. It saturates at all-ones.

## Timing
- Redirect is combinational in the decode cycle. Fetch squashes IF on redirect; there is no delay slot.
- Reset (synchronous): all register-file entries 0; ex_valid 0; all ex_* fields 0; stall_cycles 0.
- While Reset is high: id_ready=1 and redirect_valid=0.
- Reset mid-stall clears the stall state; hazard detection re-evaluates on the first cycle after Reset drops.
- ID/EX latency 1 cycle: fields appear on the Clk edge after decode.
- Write-back in cycle N is visible to a decode read in cycle N (bypass) and to the ID/EX register at edge N.

## Test plan
- lw $2,0($1) then add $3,$2,$4 -> one cycle id_ready=0 and ex_valid=0 bubble; add issues the next cycle; stall_cycles=1.
- add $5,$1,$1 then beq $5,$0,+4 -> 1 stall; beq then resolves using exmem_fwd_data=0, redirect_valid=1, redirect_pc=pc4+16.
- lw $6 then beq $6,$7 -> 2 stall cycles; operand taken from the WB bypass (wb_data=7, $7=7); branch taken.
- jal 0x0000100 at pc4=0x40000004 -> redirect_pc=0x40000400, ex_dest=31, ex_regwrite=1, no stall.
- wb_we to register 0 with 0xFFFFFFFF, then read $0 -> 0. NREG_LOG2=3 build: instr rs field 5'b11010 reads register 2.
- flush asserted during a load-use stall -> ex_valid=0, redirect_valid=0, stall_cycles unchanged. Forcing STALL_CTR_W=4 with 20 stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/id_stage_hazard_if.sv
// id_stage_hazard_if: decode-stage bus bundling IF/ID, EX/MEM, write-back and ID/EX signals
interface id_stage_hazard_if #(
    parameter int NREG_LOG2   = 5,
    parameter int CTRL_W      = 16,
    parameter int STALL_CTR_W = 16
);
    logic                   if_valid;
    logic [31:0]            if_instr;
    logic [31:0]            if_pc4;
    logic [CTRL_W-1:0]      ctrl_in;
    logic [NREG_LOG2-1:0]   exmem_regdst;
    logic                   exmem_regwrite;
    logic                   exmem_memread;
    logic [31:0]            exmem_fwd_data;
    logic                   wb_we;
    logic [NREG_LOG2-1:0]   wb_addr;
    logic [31:0]            wb_data;
    logic                   flush;
    logic                   id_ready;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic                   ex_valid;
    logic [CTRL_W-1:0]      ex_ctrl;
    logic [31:0]            ex_pc4;
    logic [31:0]            ex_rs_data;
    logic [31:0]            ex_rt_data;
    logic [31:0]            ex_imm;
    logic [NREG_LOG2-1:0]   ex_rs;
    logic [NREG_LOG2-1:0]   ex_rt;
    logic [NREG_LOG2-1:0]   ex_rd;
    logic [NREG_LOG2-1:0]   ex_dest;
    logic [4:0]             ex_shamt;
    logic [5:0]             ex_funct;
    logic [5:0]             ex_opcode;
    logic                   ex_regwrite;
    logic                   ex_memread;
    logic [STALL_CTR_W-1:0] stall_cycles;

    modport master (
        output if_valid, if_instr, if_pc4, ctrl_in, exmem_regdst, exmem_regwrite, exmem_memread,
               exmem_fwd_data, wb_we, wb_addr, wb_data, flush,
        input  id_ready, redirect_valid, redirect_pc, ex_valid, ex_ctrl, ex_pc4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_dest, ex_shamt, ex_funct, ex_opcode,
               ex_regwrite, ex_memread, stall_cycles
    );

    modport slave (
        input  if_valid, if_instr, if_pc4, ctrl_in, exmem_regdst, exmem_regwrite, exmem_memread,
               exmem_fwd_data, wb_we, wb_addr, wb_data, flush,
        output id_ready, redirect_valid, redirect_pc, ex_valid, ex_ctrl, ex_pc4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_dest, ex_shamt, ex_funct, ex_opcode,
               ex_regwrite, ex_memread, stall_cycles
    );
endinterface

// File: rtl/id_stage_hazard.sv
// id_stage_hazard: MIPS decode stage with register file, branch resolution, hazard stalls and ID/EX register
module id_stage_hazard #(
    parameter int NREG_LOG2   = 5,
    parameter int CTRL_W      = 16,
    parameter int STALL_CTR_W = 16
) (
    input logic              Clk,
    input logic              Reset,
    id_stage_hazard_if.slave bus
);
    localparam int NREG = 1 << NREG_LOG2;

    logic [31:0]            rf_q [NREG];
    logic                   ex_valid_q, ex_valid_d, ex_regwrite_q, ex_memread_q;
    logic [CTRL_W-1:0]      ex_ctrl_q;
    logic [31:0]            ex_pc4_q, ex_rs_data_q, ex_rt_data_q, ex_imm_q;
    logic [NREG_LOG2-1:0]   ex_rs_q, ex_rt_q, ex_rd_q, ex_dest_q;
    logic [4:0]             ex_shamt_q;
    logic [5:0]             ex_funct_q, ex_opcode_q;
    logic [STALL_CTR_W-1:0] stall_q, stall_d;

    logic [31:0]          instr, imm, rs_val, rt_val, fwd_rs, fwd_rt;
    logic [5:0]           op, funct;
    logic [NREG_LOG2-1:0] rs, rt, rd, dest;
    logic                 is_r, is_jr, is_beq, is_bne, is_j, is_jal, is_bj, regwrite, memread, taken;
    logic                 load_use, br_hz, ld_hz, hazard, stall, normal;

    assign instr    = bus.if_instr;
    assign op       = instr[31:26];
    assign funct    = instr[5:0];
    assign rs       = instr[21 +: NREG_LOG2];
    assign rt       = instr[16 +: NREG_LOG2];
    assign rd       = instr[11 +: NREG_LOG2];
    assign imm      = {{16{instr[15]}}, instr[15:0]};
    assign is_r     = op == 6'h00;
    assign is_jr    = is_r && funct == 6'h08;
    assign is_beq   = op == 6'h04;
    assign is_bne   = op == 6'h05;
    assign is_j     = op == 6'h02;
    assign is_jal   = op == 6'h03;
    assign is_bj    = is_beq || is_bne || is_jr;
    assign regwrite = (is_r && !is_jr) || op inside {6'h23, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h03};
    assign memread  = op == 6'h23;
    assign dest     = is_r ? rd : is_jal ? '1 : rt;

    // Register 0 is hardwired; a same-cycle write-back bypasses the array
    assign rs_val = rs == '0 ? '0 : (bus.wb_we && bus.wb_addr == rs) ? bus.wb_data : rf_q[rs];
    assign rt_val = rt == '0 ? '0 : (bus.wb_we && bus.wb_addr == rt) ? bus.wb_data : rf_q[rt];
    assign fwd_rs = (bus.exmem_regwrite && !bus.exmem_memread && bus.exmem_regdst == rs && rs != '0) ? bus.exmem_fwd_data : rs_val;
    assign fwd_rt = (bus.exmem_regwrite && !bus.exmem_memread && bus.exmem_regdst == rt && rt != '0) ? bus.exmem_fwd_data : rt_val;

    assign load_use = ex_valid_q && ex_memread_q && ex_dest_q != '0 && (ex_dest_q == rs || ex_dest_q == rt);
    assign br_hz    = is_bj && ex_valid_q && ex_regwrite_q && ex_dest_q != '0 &&
                      (ex_dest_q == rs || (!is_jr && ex_dest_q == rt));
    assign ld_hz    = is_bj && bus.exmem_memread && bus.exmem_regdst != '0 &&
                      (bus.exmem_regdst == rs || (!is_jr && bus.exmem_regdst == rt));
    assign hazard   = bus.if_valid && !is_j && (load_use || br_hz || ld_hz);
    assign stall    = hazard && !bus.flush && !Reset;
    assign normal   = !Reset && !bus.flush && !hazard;
    assign taken    = is_j || is_jal || is_jr || (is_beq && fwd_rs == fwd_rt) || (is_bne && fwd_rs != fwd_rt);

    assign bus.id_ready       = !stall;
    assign bus.redirect_valid = normal && bus.if_valid && taken;
    assign bus.redirect_pc    = is_jr ? fwd_rs :
                                (is_beq || is_bne) ? bus.if_pc4 + {imm[29:0], 2'b00} :
                                {bus.if_pc4[31:28], instr[25:0], 2'b00};

    assign ex_valid_d = normal && bus.if_valid;
    assign stall_d    = (stall && !(&stall_q)) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (bus.wb_we && bus.wb_addr != '0) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_ctrl_q     <= '0;
            ex_pc4_q      <= '0;
            ex_rs_data_q  <= '0;
            ex_rt_data_q  <= '0;
            ex_imm_q      <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            ex_dest_q     <= '0;
            ex_shamt_q    <= '0;
            ex_funct_q    <= '0;
            ex_opcode_q   <= '0;
            stall_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            stall_q    <= stall_d;
            if (normal) begin
                ex_regwrite_q <= regwrite;
                ex_memread_q  <= memread;
                ex_ctrl_q     <= bus.ctrl_in;
                ex_pc4_q      <= bus.if_pc4;
                ex_rs_data_q  <= rs_val;
                ex_rt_data_q  <= rt_val;
                ex_imm_q      <= imm;
                ex_rs_q       <= rs;
                ex_rt_q       <= rt;
                ex_rd_q       <= rd;
                ex_dest_q     <= dest;
                ex_shamt_q    <= instr[10:6];
                ex_funct_q    <= funct;
                ex_opcode_q   <= op;
            end else begin
                ex_regwrite_q <= 1'b0;
                ex_memread_q  <= 1'b0;
            end
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_regwrite  = ex_regwrite_q;
    assign bus.ex_memread   = ex_memread_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_pc4       = ex_pc4_q;
    assign bus.ex_rs_data   = ex_rs_data_q;
    assign bus.ex_rt_data   = ex_rt_data_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_dest      = ex_dest_q;
    assign bus.ex_shamt     = ex_shamt_q;
    assign bus.ex_funct     = ex_funct_q;
    assign bus.ex_opcode    = ex_opcode_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_id_stage_hazard.sv
// tb_id_stage_hazard: directed vectors for the decode stage, plus a narrow build for masking and saturation
module tb_id_stage_hazard;
    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    always #5 Clk = ~Clk;

    id_stage_hazard_if #(.NREG_LOG2(5), .CTRL_W(16), .STALL_CTR_W(16)) ifa ();
    id_stage_hazard_if #(.NREG_LOG2(3), .CTRL_W(16), .STALL_CTR_W(4))  ifb ();

    id_stage_hazard #(.NREG_LOG2(5), .CTRL_W(16), .STALL_CTR_W(16)) dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa));
    id_stage_hazard #(.NREG_LOG2(3), .CTRL_W(16), .STALL_CTR_W(4))  dut_b (.Clk(Clk), .Reset(Reset), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic wb_a(input logic [4:0] a, input logic [31:0] d);
        ifa.wb_we = 1'b1; ifa.wb_addr = a; ifa.wb_data = d;
        tick();
        ifa.wb_we = 1'b0;
    endtask

    task automatic exmem_a(input logic rw, input logic mr, input logic [4:0] rd, input logic [31:0] d);
        ifa.exmem_regwrite = rw; ifa.exmem_memread = mr; ifa.exmem_regdst = rd; ifa.exmem_fwd_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        ifa.if_valid = 1'b1; ifa.if_instr = {6'h03, 26'h100}; ifa.if_pc4 = 32'h1234; ifa.ctrl_in = 16'h1111;
        exmem_a(1'b0, 1'b0, 5'd0, 32'h0);
        ifa.wb_we = 1'b0; ifa.wb_addr = '0; ifa.wb_data = '0; ifa.flush = 1'b0;
        ifb.if_valid = 1'b0; ifb.if_instr = '0; ifb.if_pc4 = '0; ifb.ctrl_in = '0;
        ifb.exmem_regdst = '0; ifb.exmem_regwrite = 1'b0; ifb.exmem_memread = 1'b0; ifb.exmem_fwd_data = '0;
        ifb.wb_we = 1'b0; ifb.wb_addr = '0; ifb.wb_data = '0; ifb.flush = 1'b0;
        #2;
        chk("rst_id_ready", 32'(ifa.id_ready), 32'd1);
        chk("rst_redirect", 32'(ifa.redirect_valid), 32'd0);
        tick(); tick();
        chk("rst_ex_valid", 32'(ifa.ex_valid), 32'd0);
        chk("rst_ex_pc4", ifa.ex_pc4, 32'h0);
        chk("rst_ex_dest", 32'(ifa.ex_dest), 32'd0);
        chk("rst_stall_cycles", 32'(ifa.stall_cycles), 32'd0);
        Reset = 1'b0;
        ifa.if_valid = 1'b0;
        wb_a(5'd1, 32'h1000);
        wb_a(5'd5, 32'h55);
        wb_a(5'd7, 32'h7);

        // load-use: lw $2 then add $3,$2,$4
        ifa.if_valid = 1'b1; ifa.if_instr = itype(6'h23, 5'd1, 5'd2, 16'hFFF0); ifa.if_pc4 = 32'h10;
        #1 chk("lu_lw_ready", 32'(ifa.id_ready), 32'd1);
        tick();
        chk("lu_ex_imm", ifa.ex_imm, 32'hFFFFFFF0);
        chk("lu_ex_memread", 32'(ifa.ex_memread), 32'd1);
        ifa.if_instr = rtype(5'd2, 5'd4, 5'd3, 6'h20); ifa.if_pc4 = 32'h14;
        #1 chk("lu_stall_ready", 32'(ifa.id_ready), 32'd0);
        tick();
        chk("lu_bubble", 32'(ifa.ex_valid), 32'd0);
        chk("lu_stall_cnt", 32'(ifa.stall_cycles), 32'd1);
        exmem_a(1'b1, 1'b1, 5'd2, 32'h0);
        #1 chk("lu_issue_ready", 32'(ifa.id_ready), 32'd1);
        tick();
        chk("lu_add_valid", 32'(ifa.ex_valid), 32'd1);
        chk("lu_add_dest", 32'(ifa.ex_dest), 32'd3);
        chk("lu_stall_hold", 32'(ifa.stall_cycles), 32'd1);
        exmem_a(1'b0, 1'b0, 5'd0, 32'h0);

        // ALU result feeding beq: one stall then forwarded operand
        ifa.if_instr = rtype(5'd1, 5'd1, 5'd5, 6'h20); ifa.if_pc4 = 32'hFC;
        #1 chk("alu_add_ready", 32'(ifa.id_ready), 32'd1);
        tick();
        ifa.if_instr = itype(6'h04, 5'd5, 5'd0, 16'd4); ifa.if_pc4 = 32'h100;
        #1 chk("alu_br_stall", 32'(ifa.id_ready), 32'd0);
        chk("alu_br_noredir", 32'(ifa.redirect_valid), 32'd0);
        tick();
        chk("alu_stall_cnt", 32'(ifa.stall_cycles), 32'd2);
        exmem_a(1'b1, 1'b0, 5'd5, 32'h0);
        #1 chk("alu_br_ready", 32'(ifa.id_ready), 32'd1);
        chk("alu_br_taken", 32'(ifa.redirect_valid), 32'd1);
        chk("alu_br_pc", ifa.redirect_pc, 32'h110);
        tick();
        chk("alu_stall_hold", 32'(ifa.stall_cycles), 32'd2);
        exmem_a(1'b0, 1'b0, 5'd0, 32'h0);

        // load feeding beq: two stalls, operand from write-back bypass
        ifa.if_instr = itype(6'h23, 5'd1, 5'd6, 16'h0); ifa.if_pc4 = 32'h1FC;
        #1 chk("ld_lw_ready", 32'(ifa.id_ready), 32'd1);
        tick();
        ifa.if_instr = itype(6'h04, 5'd6, 5'd7, 16'd2); ifa.if_pc4 = 32'h200;
        #1 chk("ld_stall1", 32'(ifa.id_ready), 32'd0);
        tick();
        chk("ld_stall_cnt1", 32'(ifa.stall_cycles), 32'd3);
        exmem_a(1'b1, 1'b1, 5'd6, 32'h0);
        #1 chk("ld_stall2", 32'(ifa.id_ready), 32'd0);
        tick();
        chk("ld_stall_cnt2", 32'(ifa.stall_cycles), 32'd4);
        exmem_a(1'b0, 1'b0, 5'd0, 32'h0);
        ifa.wb_we = 1'b1; ifa.wb_addr = 5'd6; ifa.wb_data = 32'h7;
        #1 chk("ld_br_ready", 32'(ifa.id_ready), 32'd1);
        chk("ld_br_taken", 32'(ifa.redirect_valid), 32'd1);
        chk("ld_br_pc", ifa.redirect_pc, 32'h208);
        tick();
        chk("ld_ex_rs_bypass", ifa.ex_rs_data, 32'h7);
        chk("ld_ex_rt", ifa.ex_rt_data, 32'h7);
        ifa.wb_we = 1'b0;

        // jal: redirect, link register, control word carried
        ifa.ctrl_in = 16'hBEEF; ifa.if_instr = {6'h03, 26'h100}; ifa.if_pc4 = 32'h40000004;
        #1 chk("jal_ready", 32'(ifa.id_ready), 32'd1);
        chk("jal_redirect", 32'(ifa.redirect_valid), 32'd1);
        chk("jal_pc", ifa.redirect_pc, 32'h40000400);
        tick();
        chk("jal_dest", 32'(ifa.ex_dest), 32'd31);
        chk("jal_regwrite", 32'(ifa.ex_regwrite), 32'd1);
        chk("jal_ctrl", 32'(ifa.ex_ctrl), 32'hBEEF);
        chk("jal_pc4", ifa.ex_pc4, 32'h40000004);

        // register 0 ignores writes and is never bypassed
        ifa.wb_we = 1'b1; ifa.wb_addr = 5'd0; ifa.wb_data = 32'hFFFFFFFF;
        ifa.if_instr = rtype(5'd0, 5'd0, 5'd8, 6'h20);
        tick();
        chk("r0_bypass", ifa.ex_rs_data, 32'h0);
        ifa.wb_we = 1'b0;
        tick();
        chk("r0_read", ifa.ex_rs_data, 32'h0);

        ifa.if_instr = itype(6'h05, 5'd0, 5'd0, 16'd4);
        #1 chk("bne_not_taken", 32'(ifa.redirect_valid), 32'd0);
        tick();

        // flush during a load-use stall
        ifa.if_instr = itype(6'h23, 5'd1, 5'd9, 16'h0);
        tick();
        ifa.if_instr = rtype(5'd9, 5'd9, 5'd10, 6'h20);
        #1 chk("fl_pre_stall", 32'(ifa.id_ready), 32'd0);
        ifa.flush = 1'b1;
        #1 chk("fl_ready", 32'(ifa.id_ready), 32'd1);
        chk("fl_redirect", 32'(ifa.redirect_valid), 32'd0);
        tick();
        chk("fl_bubble", 32'(ifa.ex_valid), 32'd0);
        chk("fl_stall_cnt", 32'(ifa.stall_cycles), 32'd4);
        ifa.if_instr = {6'h03, 26'h100};
        #1 chk("fl_jal_redirect", 32'(ifa.redirect_valid), 32'd0);
        tick();
        ifa.flush = 1'b0;

        // reset in the middle of a stall
        ifa.if_instr = itype(6'h23, 5'd1, 5'd9, 16'h0);
        tick();
        ifa.if_instr = rtype(5'd9, 5'd9, 5'd10, 6'h20);
        #1 chk("rs_pre_stall", 32'(ifa.id_ready), 32'd0);
        Reset = 1'b1;
        #1 chk("rs_ready", 32'(ifa.id_ready), 32'd1);
        tick();
        chk("rs_ex_valid", 32'(ifa.ex_valid), 32'd0);
        chk("rs_stall_cnt", 32'(ifa.stall_cycles), 32'd0);
        Reset = 1'b0;
        #1 chk("rs_after_ready", 32'(ifa.id_ready), 32'd1);
        ifa.if_valid = 1'b0;

        // narrow build: upper rs bits ignored, counter saturates
        ifb.wb_we = 1'b1; ifb.wb_addr = 3'd2; ifb.wb_data = 32'hABCD;
        tick();
        ifb.wb_we = 1'b0;
        ifb.if_valid = 1'b1; ifb.if_instr = {6'h00, 5'b11010, 5'b00001, 5'b00011, 5'd0, 6'h20};
        tick();
        chk("nb_rs_data", ifb.ex_rs_data, 32'hABCD);
        chk("nb_rs_field", 32'(ifb.ex_rs), 32'd2);
        ifb.if_instr = itype(6'h04, 5'd1, 5'd1, 16'h0);
        ifb.exmem_memread = 1'b1; ifb.exmem_regdst = 3'd1;
        for (int i = 0; i < 10; i++) tick();
        chk("nb_stall_10", 32'(ifb.stall_cycles), 32'd10);
        for (int i = 0; i < 10; i++) tick();
        chk("nb_stall_sat", 32'(ifb.stall_cycles), 32'd15);
        chk("nb_still_stalled", 32'(ifb.id_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
